eeg_out_arbiter: RTL and testbench
==================================

// Module: eeg_out_arbiter
// PURPOSE
// - Packet-granular round-robin arbiter sharing the single chip output bus (CHIP_OUT_* pads) among
//   NUM_REQ internal result sources of EEG_TOP (e.g. classifier result, status, debug dump).
// - Grant holds from first beat to the beat with lst; output is registered through a 2-entry skid
//   buffer so out_* drive the pads straight from flops.
// PARAMETERS
// - NUM_REQ  4  number of requesting sources (2..8)
// - DW       8  data width, equals `CHIP_OUT_DW
// - IDW      2  source-id width, $clog2(NUM_REQ)
// PORTS
// - clk        in   1           system clock; one clock domain
// - rst_n      in   1           asynchronous, active-low reset
// - cfg_mask   in   NUM_REQ     1 = source eligible for arbitration
// - req_vld    in   NUM_REQ     per-source beat valid
// - req_lst    in   NUM_REQ     per-source last beat of packet
// - req_dat    in   NUM_REQ*DW  per-source data, source i at [i*DW +: DW]
// - req_rdy    out  NUM_REQ     per-source ready; at most one bit high
// - out_vld    out  1           to CHIP_OUT_VLD_PAD
// - out_lst    out  1           to CHIP_OUT_LST_PAD
// - out_dat    out  DW          to CHIP_OUT_DAT_PAD
// - out_rdy    in   1           from CHIP_OUT_RDY_PAD
// - out_src    out  IDW         source id of the beat on out_dat
// - busy       out  1           packet in flight (FSM != IDLE or skid not empty)
// BEHAVIOUR
// - Reset: FSM=IDLE, rr_ptr=0, grant=0, skid empty; req_rdy=0, out_vld=0, out_lst=0, out_dat=0,
//   out_src=0, busy=0. Reset mid-packet drops the partial packet; no recovery beats are emitted.
// - Handshake: beat transfers when vld&&rdy, on either side. out_vld/out_lst/out_dat/out_src are
//   held stable while out_vld && !out_rdy.
// - FSM IDLE: elig = req_vld & cfg_mask. If elig != 0, pick the first set bit searching upward
//   from rr_ptr and wrapping modulo NUM_REQ; register the grant; go to XFER. Otherwise stay.
// - FSM XFER: req_rdy[grant] = skid_has_space; all other req_rdy=0. A beat accepted with lst=1
//   sets rr_ptr = (grant+1) mod NUM_REQ and returns the FSM to IDLE.
// - Cost: one arbitration bubble per packet. Latency is 1 cycle from req_vld to req_rdy, and
//   1 cycle from beat acceptance to out_vld (skid registered).
// - Single-beat packet (vld&&lst on the first beat) is legal: XFER lasts 1 cycle.
// - cfg_mask is sampled only in IDLE. Clearing the mask bit of the granted source mid-packet does
//   not abort; the packet completes.
// - Source drops req_vld mid-packet: the grant is held (wait state); no other source is served.
// - Simultaneous events: the lst beat accepted and a new req on another source in the same cycle
//   -> new grant next cycle, with rr_ptr already updated.
// - out_rdy=0 indefinitely: skid fills (2 beats), req_rdy goes 0, nothing is lost or duplicated.
// - skid_has_space = !full. Full = 2 entries. Throughput is 1 beat/cycle with out_rdy held 1.
// STRUCTURE
// - Shared package eeg_pkg: `CHIP_OUT_DW, typedef enum logic [0:0] {ARB_IDLE, ARB_XFER} arb_st_e,
//   and typedef struct {logic lst; logic [DW-1:0] dat; logic [IDW-1:0] src} out_beat_t.
// - Sub-module eeg_skid_buf (2-entry, parameterised on beat width), also reused on the input side.
// - Round-robin pick: combinational rotate -> priority encode -> un-rotate, in this module.
// TESTING
// - Reset: rst_n low for 3 clk with all req_vld=1 -> req_rdy=0, out_vld=0, busy=0 throughout.
// - Single source: src2 sends 4 beats 0xA0..0xA3 (lst on 0xA3), out_rdy=1 -> out_dat
//   A0,A1,A2,A3, out_src=2, out_lst only on A3; first req_rdy 1 cycle after req_vld.
// - Fairness: all 4 sources continuously request 2-beat packets, mask=4'hF -> grant order
//   0,1,2,3,0,...; each source gets 25% of beats over 64 packets.
// - Backpressure: out_rdy toggled by random 30% duty during a 16-beat packet -> the byte sequence
//   out equals the sequence in; out_* stable while stalled; req_rdy low when skid full.
// - Mask: cfg_mask=4'b0101 with all sources requesting -> only sources 0,2 granted. Clear bit 0
//   mid-packet of source 0 -> that packet still completes.
// - Async reset mid-packet: assert rst_n after beat 3 of 8 -> out_vld=0 immediately. After
//   release, the next packet from src1 (1 beat, 0x5A) is output clean with out_src=1.

Source files
------------

// File: rtl/eeg_pkg.sv
// Shared types and constants for the EEG_TOP chip-output path.
package eeg_pkg;

    // Width of the CHIP_OUT_DAT pad bus and of the source id that travels with it.
    localparam int unsigned CHIP_OUT_DW  = 8;
    localparam int unsigned CHIP_OUT_IDW = 2;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_XFER
    } arb_st_e;

    // One beat as presented on the output pads at the default widths.
    typedef struct packed {
        logic                    lst;
        logic [CHIP_OUT_DW-1:0]  dat;
        logic [CHIP_OUT_IDW-1:0] src;
    } out_beat_t;

endpackage

// File: rtl/eeg_skid_buf.sv
// Two-entry skid buffer: the head register drives the outputs directly, the skid register
// catches the beat accepted in the cycle the downstream stalls. Accepts 1 beat/cycle when the
// downstream keeps ready high.
module eeg_skid_buf #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_vld_i,
    output logic             in_rdy_o,
    input  logic [Width-1:0] in_dat_i,
    output logic             out_vld_o,
    output logic [Width-1:0] out_dat_o,
    input  logic             out_rdy_i
);

    logic             head_vld_q, head_vld_d;
    logic [Width-1:0] head_q, head_d;
    logic             skid_vld_q, skid_vld_d;
    logic [Width-1:0] skid_q, skid_d;
    logic             push, pop;

    // The skid slot is only ever occupied while the head is, so "full" is just skid_vld_q.
    assign in_rdy_o  = !skid_vld_q;
    assign out_vld_o = head_vld_q;
    assign out_dat_o = head_q;

    // Next-state: refill the head from skid first (ordering), then from the input.
    always_comb begin
        head_vld_d = head_vld_q;
        head_d     = head_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        push       = in_vld_i && !skid_vld_q;
        pop        = head_vld_q && out_rdy_i;
        if (pop || !head_vld_q) begin
            if (skid_vld_q) begin
                head_d     = skid_q;
                head_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (push) begin
                head_d     = in_dat_i;
                head_vld_d = 1'b1;
            end else begin
                head_vld_d = 1'b0;
            end
        end else if (push) begin
            skid_d     = in_dat_i;
            skid_vld_d = 1'b1;
        end
    end

    // State registers; reset empties both slots and clears the pad data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_vld_q <= 1'b0;
            head_q     <= '0;
            skid_vld_q <= 1'b0;
            skid_q     <= '0;
        end else begin
            head_vld_q <= head_vld_d;
            head_q     <= head_d;
            skid_vld_q <= skid_vld_d;
            skid_q     <= skid_d;
        end
    end

endmodule

// File: rtl/eeg_out_arbiter.sv
// Packet-granular round-robin arbiter for the chip output bus. A grant is taken in IDLE and
// held until the lst beat of that source is accepted; beats leave through a registered skid
// buffer so the pads are driven from flops.
module eeg_out_arbiter
    import eeg_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DW      = CHIP_OUT_DW,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   cfg_mask_i,
    input  logic [NUM_REQ-1:0]   req_vld_i,
    input  logic [NUM_REQ-1:0]   req_lst_i,
    input  logic [NUM_REQ*DW-1:0] req_dat_i,
    output logic [NUM_REQ-1:0]   req_rdy_o,
    output logic                 out_vld_o,
    output logic                 out_lst_o,
    output logic [DW-1:0]        out_dat_o,
    input  logic                 out_rdy_i,
    output logic [IDW-1:0]       out_src_o,
    output logic                 busy_o
);

    typedef struct packed {
        logic           lst;
        logic [DW-1:0]  dat;
        logic [IDW-1:0] src;
    } beat_t;

    arb_st_e          state_q, state_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] elig, rot;
    logic             any_elig;
    logic [IDW-1:0]   pick;
    logic [IDW-1:0]   grant_nxt;
    int               pick_ofs;
    logic             skid_in_vld, skid_in_rdy, skid_out_vld;
    beat_t            in_beat, out_beat;

    // Round-robin pick: rotate so rr_ptr is bit 0, take the lowest set bit, rotate back.
    always_comb begin
        elig     = req_vld_i & cfg_mask_i;
        any_elig = |elig;
        rot      = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            rot[i] = elig[(i + int'(rr_ptr_q)) % int'(NUM_REQ)];
        end
        pick_ofs = 0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pick_ofs = i;
            end
        end
        pick = IDW'((pick_ofs + int'(rr_ptr_q)) % int'(NUM_REQ));
    end

    assign grant_nxt = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + IDW'(1);

    // FSM next-state and per-source ready.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        req_rdy_o = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (any_elig) begin
                    grant_d = pick;
                    state_d = ARB_XFER;
                end
            end
            ARB_XFER: begin
                req_rdy_o[grant_q] = skid_in_rdy;
                if (req_vld_i[grant_q] && skid_in_rdy && req_lst_i[grant_q]) begin
                    rr_ptr_d = grant_nxt;
                    state_d  = ARB_IDLE;
                end
            end
        endcase
    end

    // FSM, grant and round-robin pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign skid_in_vld = (state_q == ARB_XFER) && req_vld_i[grant_q];
    assign in_beat.lst = req_lst_i[grant_q];
    assign in_beat.dat = req_dat_i[int'(grant_q) * DW +: DW];
    assign in_beat.src = grant_q;

    eeg_skid_buf #(
        .Width($bits(beat_t))
    ) u_skid (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .in_vld_i (skid_in_vld),
        .in_rdy_o (skid_in_rdy),
        .in_dat_i (in_beat),
        .out_vld_o(skid_out_vld),
        .out_dat_o(out_beat),
        .out_rdy_i(out_rdy_i)
    );

    assign out_vld_o = skid_out_vld;
    assign out_lst_o = out_beat.lst;
    assign out_dat_o = out_beat.dat;
    assign out_src_o = out_beat.src;
    assign busy_o    = (state_q == ARB_XFER) || skid_out_vld;

endmodule

// File: tb/tb_eeg_out_arbiter.sv
// Self-checking bench for eeg_out_arbiter: per-source beat queues feed the DUT, accepted
// beats go to a scoreboard that is checked against the output handshakes.
module tb_eeg_out_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    typedef struct packed {
        logic          lst;
        logic [DW-1:0] dat;
    } sbeat_t;

    typedef struct packed {
        logic          lst;
        logic [DW-1:0] dat;
        logic [1:0]    src;
    } obeat_t;

    typedef struct {
        logic [NR-1:0] mask;
        logic [NR-1:0] vld;
        int            exp_src;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR-1:0]    cfg_mask = '1;
    logic [NR-1:0]    req_vld = '0;
    logic [NR-1:0]    req_lst = '0;
    logic [NR*DW-1:0] req_dat = '0;
    logic [NR-1:0]    req_rdy;
    logic             out_vld, out_lst, out_rdy = 1'b1;
    logic [DW-1:0]    out_dat;
    logic [1:0]       out_src;
    logic             busy;

    sbeat_t srcq[NR][$];
    obeat_t sb[$];
    int     sop_src[$];
    bit     hs[NR];
    bit     in_pkt[NR];
    int     out_cnt[NR];
    int     first_vld[NR];
    int     first_rdy[NR];
    bit     one_shot = 1'b0;
    int     rdy_mode = 0;
    int     full_seen = 0;
    int     cyc = 0;
    int     n_chk = 0;
    int     n_fail = 0;
    logic   stall_prev = 1'b0;
    logic [11:0] prev_out = '0;
    vec_t   vt[11];

    eeg_out_arbiter #(
        .NUM_REQ(NR),
        .DW     (DW),
        .IDW    (2)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .cfg_mask_i(cfg_mask),
        .req_vld_i (req_vld),
        .req_lst_i (req_lst),
        .req_dat_i (req_dat),
        .req_rdy_o (req_rdy),
        .out_vld_o (out_vld),
        .out_lst_o (out_lst),
        .out_dat_o (out_dat),
        .out_rdy_i (out_rdy),
        .out_src_o (out_src),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_nclk();
        @(negedge clk);
        #1;
    endtask

    task automatic push_pkt(input int s, input int len, input logic [DW-1:0] base);
        sbeat_t b;
        for (int k = 0; k < len; k++) begin
            b.lst = (k == len - 1);
            b.dat = base + DW'(k);
            srcq[s].push_back(b);
        end
    endtask

    task automatic clear_bench();
        for (int i = 0; i < NR; i++) begin
            srcq[i].delete();
            hs[i]        = 1'b0;
            in_pkt[i]    = 1'b0;
            out_cnt[i]   = 0;
            first_vld[i] = -1;
            first_rdy[i] = -1;
        end
        sb.delete();
        sop_src.delete();
        stall_prev = 1'b0;
    endtask

    // Asynchronous reset applied between clock edges; optionally with every source requesting.
    task automatic do_reset(input bit load_all);
        wait_nclk();
        #1;
        rst_n = 1'b0;
        clear_bench();
        if (load_all) begin
            for (int i = 0; i < NR; i++) push_pkt(i, 1, DW'(8'hE0 + i));
        end
        repeat (3) begin
            @(negedge clk);
            chk("rst_req_rdy", req_rdy, 0);
            chk("rst_out_vld", out_vld, 0);
            chk("rst_busy", busy, 0);
            chk("rst_out_dat_src", {out_lst, out_dat, out_src}, 0);
        end
        #2;
        rst_n = 1'b1;
    endtask

    task automatic drain(input logic [NR-1:0] m, input int budget);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            wait_nclk();
            n++;
            done = (sb.size() == 0) && !busy;
            for (int i = 0; i < NR; i++) begin
                if (m[i] && srcq[i].size() != 0) done = 1'b0;
            end
        end
        chk("drain_done", done, 1);
    endtask

    task automatic wait_sop(input int cnt, input int budget);
        int n = 0;
        while (sop_src.size() < cnt && n < budget) begin
            wait_nclk();
            n++;
        end
        chk("sop_reached", (sop_src.size() >= cnt), 1);
    endtask

    // Monitor: handshakes observed mid-cycle, committed at the following rising edge.
    initial begin
        obeat_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("rdy_onehot", ($countones(req_rdy) <= 1), 1);
                if (sb.size() >= 2) begin
                    full_seen++;
                    chk("rdy_low_when_full", req_rdy, 0);
                end
                if (stall_prev) begin
                    chk("stall_stable", {out_vld, out_lst, out_dat, out_src}, prev_out);
                end
                if (out_vld && out_rdy) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL out_unexpected: actual=0x%0h required=none",
                                 {out_lst, out_dat, out_src});
                    end else begin
                        e = sb.pop_front();
                        chk("out_beat", {out_lst, out_dat, out_src}, e);
                        out_cnt[out_src]++;
                    end
                end
                for (int i = 0; i < NR; i++) begin
                    if (req_vld[i] && first_vld[i] < 0) first_vld[i] = cyc;
                    if (req_rdy[i] && first_rdy[i] < 0) first_rdy[i] = cyc;
                    if (req_vld[i] && req_rdy[i] && srcq[i].size() != 0) begin
                        e.lst = srcq[i][0].lst;
                        e.dat = srcq[i][0].dat;
                        e.src = 2'(i);
                        sb.push_back(e);
                        if (!in_pkt[i]) sop_src.push_back(i);
                        in_pkt[i] = !srcq[i][0].lst;
                        hs[i]     = 1'b1;
                    end
                end
                stall_prev = out_vld && !out_rdy;
                prev_out   = {out_vld, out_lst, out_dat, out_src};
            end
        end
    end

    // Source driver and output-ready generator; inputs change 1 time unit after the edge.
    initial begin
        bit any;
        forever begin
            @(posedge clk);
            #1;
            any = 1'b0;
            for (int i = 0; i < NR; i++) begin
                if (hs[i]) begin
                    hs[i] = 1'b0;
                    any   = 1'b1;
                    if (srcq[i].size() != 0) void'(srcq[i].pop_front());
                end
            end
            if (one_shot && any) begin
                for (int i = 0; i < NR; i++) srcq[i].delete();
            end
            for (int i = 0; i < NR; i++) begin
                if (srcq[i].size() != 0) begin
                    req_vld[i]           = 1'b1;
                    req_lst[i]           = srcq[i][0].lst;
                    req_dat[i*DW +: DW]  = srcq[i][0].dat;
                end else begin
                    req_vld[i] = 1'b0;
                    req_lst[i] = 1'b0;
                end
            end
            out_rdy = (rdy_mode == 1) ? ($urandom_range(99) < 30) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // {mask, vld, expected first grant}; rr_ptr carries from one vector to the next.
        vt[0]  = '{4'hF,    4'b1111, 0};
        vt[1]  = '{4'hF,    4'b0001, 0};
        vt[2]  = '{4'hF,    4'b1100, 2};
        vt[3]  = '{4'hF,    4'b0111, 0};
        vt[4]  = '{4'b0101, 4'b1111, 2};
        vt[5]  = '{4'b0101, 4'b1111, 0};
        vt[6]  = '{4'b1000, 4'b1010, 3};
        vt[7]  = '{4'hF,    4'b1010, 1};
        vt[8]  = '{4'hF,    4'b0010, 1};
        vt[9]  = '{4'b1110, 4'b1111, 2};
        vt[10] = '{4'hF,    4'b1001, 3};

        clear_bench();

        // Reset with every source requesting, then let those packets drain.
        do_reset(1'b1);
        drain(4'hF, 100);

        // Arbitration vectors: only the first winner of each vector is let through.
        do_reset(1'b0);
        one_shot = 1'b1;
        for (int v = 0; v < 11; v++) begin
            int base;
            cfg_mask = vt[v].mask;
            base     = sop_src.size();
            for (int i = 0; i < NR; i++) begin
                if (vt[v].vld[i]) push_pkt(i, 1, DW'(8'h10 + v * 4 + i));
            end
            wait_sop(base + 1, 20);
            if (sop_src.size() > base) chk("arb_vec_grant", sop_src[base], vt[v].exp_src);
            drain(4'hF, 50);
        end
        one_shot = 1'b0;
        cfg_mask = 4'hF;

        // Single source, 4 beats, ready 1 cycle after valid.
        do_reset(1'b0);
        push_pkt(2, 4, 8'hA0);
        wait_nclk();
        chk("busy_before_grant", busy, 0);
        wait_nclk();
        chk("busy_in_flight", busy, 1);
        drain(4'b0100, 50);
        chk("rdy_latency", first_rdy[2] - first_vld[2], 1);
        chk("single_cnt", out_cnt[2], 4);

        // Fairness: 16 two-beat packets per source, all requesting together.
        do_reset(1'b0);
        for (int p = 0; p < 16; p++) begin
            for (int i = 0; i < NR; i++) push_pkt(i, 2, DW'(i * 64 + p * 2));
        end
        wait_sop(64, 600);
        drain(4'hF, 100);
        for (int k = 0; k < 64; k++) begin
            if (k < sop_src.size()) chk("rr_order", sop_src[k], k % 4);
        end
        for (int i = 0; i < NR; i++) chk("rr_share", out_cnt[i], 32);

        // Backpressure: random 30% ready during a 16-beat packet.
        do_reset(1'b0);
        full_seen = 0;
        rdy_mode  = 1;
        push_pkt(1, 16, 8'h30);
        drain(4'b0010, 800);
        rdy_mode = 0;
        chk("skid_filled", (full_seen > 0), 1);
        chk("bp_cnt", out_cnt[1], 16);

        // Mask 0101: only sources 0 and 2 are ever granted.
        do_reset(1'b0);
        cfg_mask = 4'b0101;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < NR; i++) push_pkt(i, 2, DW'(8'h40 + i * 16 + p * 2));
        end
        wait_sop(6, 200);
        drain(4'b0101, 100);
        repeat (5) wait_nclk();
        chk("mask_pkt_cnt", sop_src.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < sop_src.size()) chk("mask_order", sop_src[k], (k % 2) ? 2 : 0);
        end

        // Clearing the granted source's mask bit mid-packet does not abort it.
        do_reset(1'b0);
        cfg_mask = 4'b0101;
        push_pkt(0, 4, 8'hC0);
        wait_sop(1, 20);
        cfg_mask = 4'b0100;
        drain(4'b0001, 50);
        chk("mask_midpkt_cnt", out_cnt[0], 4);
        cfg_mask = 4'hF;

        // Asynchronous reset after 3 of 8 beats, then a clean 1-beat packet from source 1.
        do_reset(1'b0);
        push_pkt(0, 8, 8'h80);
        begin
            int n = 0;
            while (out_cnt[0] < 3 && n < 50) begin
                wait_nclk();
                n++;
            end
            chk("pre_rst_beats", (out_cnt[0] >= 3), 1);
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_vld", out_vld, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_req_rdy", req_rdy, 0);
        clear_bench();
        repeat (3) wait_nclk();
        rst_n = 1'b1;
        push_pkt(1, 1, 8'h5A);
        drain(4'b0010, 30);
        chk("post_rst_src1_cnt", out_cnt[1], 1);
        chk("post_rst_src0_cnt", out_cnt[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
